// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: datapath width, op codes and FSM states.
package alu_pkg;

  localparam int ALU_W = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_t;

  function automatic logic is_zero(input logic [ALU_W-1:0] v);
    return (v == {ALU_W{1'b0}});
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id
);

  logic [IDW-1:0] idx_s;

  // Scan offsets from highest to lowest so the smallest offset from ptr wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = {IDW{1'b0}};
    idx_s     = {IDW{1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx_s     = IDW'((int'(ptr) + i) % NREQ);
      gnt_id    = req[idx_s] ? idx_s : gnt_id;
      gnt_valid = gnt_valid | req[idx_s];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 16-bit ALU between NREQ requesters.
// Optional result-is-zero flag on the response channel: define ALU_ARB_ZFLAG_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [ALU_W*NREQ-1:0] req_a,
  input  logic [ALU_W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [1:0]            alu_op,
  output logic [ALU_W-1:0]      alu_i0,
  output logic [ALU_W-1:0]      alu_i1,
  input  logic [ALU_W-1:0]      alu_o,
  input  logic                  alu_cout,
  output logic                  resp_valid,
  output logic [IDW-1:0]        resp_id,
  output logic [ALU_W-1:0]      resp_o,
  output logic                  resp_cout,
  input  logic                  resp_ready
`ifdef ALU_ARB_ZFLAG_EN
  ,
  output logic                  resp_zero
`endif
);

  arb_state_t       state_r;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   id_r;
  logic [1:0]       op_r;
  logic [ALU_W-1:0] a_r;
  logic [ALU_W-1:0] b_r;
  logic             valid_r;
  logic [ALU_W-1:0] res_r;
  logic             cout_r;
`ifdef ALU_ARB_ZFLAG_EN
  logic             zero_r;
`endif

  logic             gnt_valid_s;
  logic [IDW-1:0]   gnt_id_s;
  logic             grant_s;
  logic [IDW-1:0]   next_ptr_s;
  logic [1:0]       sel_op_s;
  logic [ALU_W-1:0] sel_a_s;
  logic [ALU_W-1:0] sel_b_s;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req       (req_valid),
    .ptr       (ptr_r),
    .gnt_valid (gnt_valid_s),
    .gnt_id    (gnt_id_s)
  );

  assign grant_s    = (state_r == ST_IDLE) && gnt_valid_s;
  assign next_ptr_s = (gnt_id_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : gnt_id_s + IDW'(1);

  // Operand/op mux for the requester currently being picked.
  always_comb begin
    sel_op_s = 2'b00;
    sel_a_s  = {ALU_W{1'b0}};
    sel_b_s  = {ALU_W{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      sel_op_s = (gnt_id_s == IDW'(k)) ? req_op[2*k +: 2]         : sel_op_s;
      sel_a_s  = (gnt_id_s == IDW'(k)) ? req_a[ALU_W*k +: ALU_W] : sel_a_s;
      sel_b_s  = (gnt_id_s == IDW'(k)) ? req_b[ALU_W*k +: ALU_W] : sel_b_s;
    end
  end

  // Accept pulse is combinational so the requester sees it in the grant cycle itself.
  always_comb begin
    req_ready = {NREQ{1'b0}};
    if (grant_s) begin
      req_ready[gnt_id_s] = 1'b1;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
  end

  // FSM, operand latch and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= {IDW{1'b0}};
      id_r    <= {IDW{1'b0}};
      op_r    <= 2'b00;
      a_r     <= {ALU_W{1'b0}};
      b_r     <= {ALU_W{1'b0}};
      valid_r <= 1'b0;
      res_r   <= {ALU_W{1'b0}};
      cout_r  <= 1'b0;
`ifdef ALU_ARB_ZFLAG_EN
      zero_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (gnt_valid_s) begin
            op_r    <= sel_op_s;
            a_r     <= sel_a_s;
            b_r     <= sel_b_s;
            id_r    <= gnt_id_s;
            ptr_r   <= next_ptr_s;
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_r   <= alu_o;
          cout_r  <= alu_cout;
`ifdef ALU_ARB_ZFLAG_EN
          zero_r  <= is_zero(alu_o);
`endif
          valid_r <= 1'b1;
          state_r <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            valid_r <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_op     = op_r;
  assign alu_i0     = a_r;
  assign alu_i1     = b_r;
  assign resp_valid = valid_r;
  assign resp_id    = id_r;
  assign resp_o     = res_r;
  assign resp_cout  = cout_r;
`ifdef ALU_ARB_ZFLAG_EN
  assign resp_zero  = zero_r;
`endif

endmodule
